// File: rtl/alu_issue_ctrl.sv
// Request queue, credit-gated issue and in-order result collection around the
// fixed-latency HW2_alu; results are never dropped because issue is bounded by free response slots.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int ALU_LAT    = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk_p_i,
  input  logic             reset_p_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_a_i,
  input  logic [7:0]       req_b_i,
  input  logic [2:0]       req_inst_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [2:0]       alu_inst_o,
  input  logic [15:0]      alu_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [15:0]      rsp_data_o,
  output logic [2:0]       rsp_inst_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  localparam int QPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int QCW = $clog2(FIFO_DEPTH + 1);
  localparam int RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int RCW = $clog2(RSP_DEPTH + 1);
  localparam logic [2:0] INST_ILL = 3'b111;

  logic [7:0]       qa_q [FIFO_DEPTH];
  logic [7:0]       qb_q [FIFO_DEPTH];
  logic [2:0]       qi_q [FIFO_DEPTH];
  logic [TAG_W-1:0] qt_q [FIFO_DEPTH];
  logic [QPW-1:0]   q_wr_q, q_rd_q;
  logic [QCW-1:0]   q_cnt_q, q_cnt_d;

  logic [15:0]      rdat_q [RSP_DEPTH];
  logic [2:0]       rins_q [RSP_DEPTH];
  logic [TAG_W-1:0] rtag_q [RSP_DEPTH];
  logic             rerr_q [RSP_DEPTH];
  logic [RPW-1:0]   r_wr_q, r_rd_q;
  logic [RCW-1:0]   r_cnt_q, r_cnt_d;
  logic [RCW-1:0]   crd_q, crd_d;

  logic [7:0]       alu_a_q, alu_b_q;
  logic [2:0]       alu_inst_q;

  // Stage k describes the op whose operands were on the ALU ports k cycles ago.
  logic [ALU_LAT:0] pv_q, perr_q;
  logic [2:0]       pi_q [ALU_LAT+1];
  logic [TAG_W-1:0] pt_q [ALU_LAT+1];

  logic        push, issue, rsp_hs, cap, hd_ill;
  logic [15:0] cap_data;

  assign req_ready_o = (q_cnt_q != QCW'(FIFO_DEPTH));
  assign push        = req_valid_i & req_ready_o;
  assign rsp_valid_o = (r_cnt_q != '0);
  assign rsp_hs      = rsp_valid_o & rsp_ready_i;
  assign issue       = (q_cnt_q != '0) & ((crd_q != '0) | rsp_hs);
  assign hd_ill      = (qi_q[q_rd_q] == INST_ILL);
  assign cap         = pv_q[ALU_LAT];
  assign cap_data    = perr_q[ALU_LAT] ? 16'h0000 : alu_data_i;

  always_comb begin
    q_cnt_d = q_cnt_q + QCW'(push) - QCW'(issue);
    r_cnt_d = r_cnt_q + RCW'(cap) - RCW'(rsp_hs);
    crd_d   = crd_q - RCW'(issue) + RCW'(rsp_hs);
  end

  always_ff @(posedge clk_p_i) begin
    if (push) begin
      qa_q[q_wr_q] <= req_a_i;
      qb_q[q_wr_q] <= req_b_i;
      qi_q[q_wr_q] <= req_inst_i;
      qt_q[q_wr_q] <= req_tag_i;
    end
    if (cap) begin
      rdat_q[r_wr_q] <= cap_data;
      rins_q[r_wr_q] <= pi_q[ALU_LAT];
      rtag_q[r_wr_q] <= pt_q[ALU_LAT];
      rerr_q[r_wr_q] <= perr_q[ALU_LAT];
    end
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      q_cnt_q    <= '0;
      r_wr_q     <= '0;
      r_rd_q     <= '0;
      r_cnt_q    <= '0;
      crd_q      <= RCW'(RSP_DEPTH);
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_inst_q <= '0;
      pv_q       <= '0;
      perr_q     <= '0;
      for (int k = 0; k <= ALU_LAT; k++) begin
        pi_q[k] <= '0;
        pt_q[k] <= '0;
      end
    end else begin
      q_cnt_q <= q_cnt_d;
      r_cnt_q <= r_cnt_d;
      crd_q   <= crd_d;
      if (push)  q_wr_q <= q_wr_q + QPW'(1);
      if (issue) q_rd_q <= q_rd_q + QPW'(1);
      if (cap)    r_wr_q <= (r_wr_q == RPW'(RSP_DEPTH - 1)) ? '0 : r_wr_q + RPW'(1);
      if (rsp_hs) r_rd_q <= (r_rd_q == RPW'(RSP_DEPTH - 1)) ? '0 : r_rd_q + RPW'(1);
      // Illegal ops keep their slot but present an all-zero operation to the ALU.
      alu_a_q    <= (issue & !hd_ill) ? qa_q[q_rd_q] : '0;
      alu_b_q    <= (issue & !hd_ill) ? qb_q[q_rd_q] : '0;
      alu_inst_q <= (issue & !hd_ill) ? qi_q[q_rd_q] : '0;
      pv_q       <= {pv_q[ALU_LAT-1:0], issue};
      perr_q     <= {perr_q[ALU_LAT-1:0], issue & hd_ill};
      pi_q[0]    <= issue ? qi_q[q_rd_q] : '0;
      pt_q[0]    <= issue ? qt_q[q_rd_q] : '0;
      for (int k = 1; k <= ALU_LAT; k++) begin
        pi_q[k] <= pi_q[k-1];
        pt_q[k] <= pt_q[k-1];
      end
    end
  end

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_inst_o = alu_inst_q;

  assign rsp_data_o = rsp_valid_o ? rdat_q[r_rd_q] : '0;
  assign rsp_inst_o = rsp_valid_o ? rins_q[r_rd_q] : '0;
  assign rsp_tag_o  = rsp_valid_o ? rtag_q[r_rd_q] : '0;
  assign rsp_err_o  = rsp_valid_o ? rerr_q[r_rd_q] : 1'b0;

  assign busy_o = (q_cnt_q != '0) | (|pv_q) | rsp_valid_o;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a 2-cycle behavioural ALU that returns
// junk (0xBAD0) whenever it is handed an all-zero operation.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  localparam int TAG_W     = 4;
  localparam int RSP_DEPTH = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [2:0]       inst;
    logic [15:0]      data;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_p_i = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [7:0] req_a_i = '0, req_b_i = '0;
  logic [2:0] req_inst_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic [7:0] alu_a_o, alu_b_o;
  logic [2:0] alu_inst_o;
  logic [15:0] alu_data_i;
  logic rsp_valid_o;
  logic rsp_ready_i = 1'b1;
  logic [15:0] rsp_data_o;
  logic [2:0] rsp_inst_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic rsp_err_o, busy_o;

  alu_issue_ctrl #(.FIFO_DEPTH(4), .RSP_DEPTH(RSP_DEPTH), .ALU_LAT(2), .TAG_W(TAG_W)) dut (
    .clk_p_i(clk), .reset_p_i(reset_p_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_inst_i(req_inst_i), .req_tag_i(req_tag_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_inst_o(alu_inst_o), .alu_data_i(alu_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_inst_o(rsp_inst_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_rsp = 0, cyc = 0, inv_prints = 0;
  rsp_t sb_q[$];
  int rsp_cyc[$];
  logic [18:0] alu_log [int];
  bit rand_rdy = 1'b0;
  rsp_t mon_got, mon_exp;
  logic [18:0] alu_p1 = '0, alu_p2 = '0;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] abs_a;
    abs_a = a[7] ? (~a + 8'd1) : a;
    case (op)
      3'd0: return {8'h00, a} + {8'h00, b};
      3'd1: return {8'h00, b} - {8'h00, a};
      3'd2: return {8'h00, a} * {8'h00, b};
      3'd3: return {8'h00, a & b};
      3'd4: return {8'h00, a ^ b};
      3'd5: return {8'h00, abs_a};
      3'd6: return ({8'h00, b} - {8'h00, a}) << 2;
      default: return 16'hBAD0;
    endcase
  endfunction

  function automatic rsp_t mk(input logic [TAG_W-1:0] tag, input logic [2:0] op,
                              input logic [15:0] d, input logic e);
    rsp_t r;
    r.tag = tag; r.inst = op; r.data = d; r.err = e;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    alu_p1 <= {alu_a_o, alu_b_o, alu_inst_o};
    alu_p2 <= alu_p1;
  end
  assign alu_data_i = (alu_p2 == '0) ? 16'hBAD0 : alu_f(alu_p2[18:11], alu_p2[10:3], alu_p2[2:0]);

  always @(negedge clk) begin
    alu_log[cyc] = {alu_a_o, alu_b_o, alu_inst_o};
    if (!reset_p_i) begin
      n_cmp++;
      if (int'(dut.crd_q) + $countones(dut.pv_q) + int'(dut.r_cnt_q) != RSP_DEPTH
          || int'(dut.r_cnt_q) > RSP_DEPTH) begin
        n_err++;
        if (inv_prints < 5)
          $display("FAIL credit_invariant cyc=%0d crd=%0d inflight=%0d rsp_cnt=%0d sum_required=%0d",
                   cyc, dut.crd_q, $countones(dut.pv_q), dut.r_cnt_q, RSP_DEPTH);
        inv_prints++;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        n_cmp++;
        n_rsp++;
        rsp_cyc.push_back(cyc);
        mon_got = rsp_t'({rsp_tag_o, rsp_inst_o, rsp_data_o, rsp_err_o});
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected cyc=%0d got tag=%0d data=%h required=no response",
                   cyc, rsp_tag_o, rsp_data_o);
        end else begin
          mon_exp = sb_q.pop_front();
          if (mon_got !== mon_exp)
            begin
              n_err++;
              $display("FAIL rsp_data cyc=%0d got tag=%0d inst=%0d data=%h err=%b required tag=%0d inst=%0d data=%h err=%b",
                       cyc, mon_got.tag, mon_got.inst, mon_got.data, mon_got.err,
                       mon_exp.tag, mon_exp.inst, mon_exp.data, mon_exp.err);
            end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [TAG_W-1:0] tag, input rsp_t exp, output bit acc);
    req_valid_i = 1'b1; req_a_i = a; req_b_i = b; req_inst_i = op; req_tag_i = tag;
    @(negedge clk);
    acc = req_ready_o;
    if (acc) sb_q.push_back(exp);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [TAG_W-1:0] tag, input rsp_t exp, output int t_acc);
    bit acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) offer(a, b, op, tag, exp, acc);
    t_acc = cyc;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout tag=%0d accepted=0 required=1", tag);
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    bit done;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      done = !busy_o;
      tick();
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1 reset_p_i = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready_o, alu_a_o, alu_b_o, alu_inst_o} !== {1'b1, 19'd0}) begin
      n_err++;
      $display("FAIL reset_req_alu got rdy=%b a=%h b=%h inst=%0d required rdy=1 a=0 b=0 inst=0",
               req_ready_o, alu_a_o, alu_b_o, alu_inst_o);
    end
    n_cmp++;
    if ({rsp_valid_o, rsp_data_o, rsp_inst_o, rsp_tag_o, rsp_err_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp got valid=%b data=%h inst=%0d tag=%0d err=%b busy=%b required all 0",
               rsp_valid_o, rsp_data_o, rsp_inst_o, rsp_tag_o, rsp_err_o, busy_o);
    end
    tick(); tick();
    reset_p_i = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({req_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release got rdy=%b busy=%b valid=%b required 1 0 0", req_ready_o, busy_o, rsp_valid_o);
    end
    tick();
  endtask

  task automatic check_latency(input string name, input int t);
    int lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin lat = cyc - t + 1; tick(); break; end
      tick();
    end
    n_cmp++;
    if (lat != 5) begin
      n_err++;
      $display("FAIL %s_latency got=%0d required=5", name, lat);
    end
  endtask

  task automatic test_single();
    int t, n0;
    bit ok;
    rsp_ready_i = 1'b1;
    n0 = n_rsp;
    send(8'd200, 8'd100, 3'd0, 4'd3, mk(4'd3, 3'd0, 16'h012C, 1'b0), t);
    check_latency("single", t);
    wait_idle(20, ok);
    n_cmp++;
    if (alu_log[t+1] !== {8'd200, 8'd100, 3'd0}) begin
      n_err++;
      $display("FAIL single_alu_ports got=%h required=%h", alu_log[t+1], {8'd200, 8'd100, 3'd0});
    end
    n_cmp++;
    if (!ok || n_rsp - n0 != 1 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL single_count idle=%b responses=%0d pending=%0d required idle=1 responses=1 pending=0",
               ok, n_rsp - n0, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta [5] = '{8'd5, 8'd255, 8'h80, 8'd1, 8'hF0};
    logic [7:0]  tb [5] = '{8'd3, 8'd255, 8'h00, 8'd3, 8'h3C};
    logic [2:0]  to [5] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd3};
    logic [15:0] te [5] = '{16'hFFFE, 16'hFE01, 16'h0080, 16'h0008, 16'h0030};
    int t, n0;
    bit ok;
    rsp_cyc.delete();
    n0 = n_rsp;
    for (int i = 0; i < 5; i++)
      send(ta[i], tb[i], to[i], TAG_W'(i), mk(TAG_W'(i), to[i], te[i], 1'b0), t);
    wait_idle(40, ok);
    n_cmp++;
    if (!ok || n_rsp - n0 != 5 || rsp_cyc.size() != 5) begin
      n_err++;
      $display("FAIL b2b_count idle=%b responses=%0d required idle=1 responses=5", ok, n_rsp - n0);
    end else if (rsp_cyc[4] - rsp_cyc[0] != 4) begin
      n_err++;
      $display("FAIL b2b_consecutive span=%0d required=4", rsp_cyc[4] - rsp_cyc[0]);
    end
  endtask

  task automatic test_backpressure();
    int k = 0, n0;
    bit acc, ok, rdy;
    rsp_ready_i = 1'b0;
    n0 = n_rsp;
    for (int c = 0; c < 30; c++) begin
      offer(8'(10 + k), 8'(k), 3'd0, TAG_W'(k), mk(TAG_W'(k), 3'd0, 16'(10 + 2 * k), 1'b0), acc);
      if (acc) k++;
    end
    @(negedge clk);
    rdy = req_ready_o;
    tick();
    n_cmp++;
    if (k != 8 || rdy !== 1'b0 || n_rsp != n0) begin
      n_err++;
      $display("FAIL bp_stall accepted=%0d ready=%b responses=%0d required accepted=8 ready=0 responses=0",
               k, rdy, n_rsp - n0);
    end
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 60 && k < 10; c++) begin
      offer(8'(10 + k), 8'(k), 3'd0, TAG_W'(k), mk(TAG_W'(k), 3'd0, 16'(10 + 2 * k), 1'b0), acc);
      if (acc) k++;
    end
    wait_idle(60, ok);
    n_cmp++;
    if (k != 10 || !ok || n_rsp - n0 != 10 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain accepted=%0d idle=%b responses=%0d pending=%0d required 10 1 10 0",
               k, ok, n_rsp - n0, sb_q.size());
    end
  endtask

  task automatic test_illegal();
    int t1, t2, t3, n0;
    bit ok;
    rsp_ready_i = 1'b1;
    n0 = n_rsp;
    send(8'd10, 8'd20, 3'd0, 4'd1, mk(4'd1, 3'd0, 16'd30, 1'b0), t1);
    send(8'd7,  8'd9,  3'd7, 4'd2, mk(4'd2, 3'd7, 16'h0000, 1'b1), t2);
    send(8'd1,  8'd2,  3'd0, 4'd3, mk(4'd3, 3'd0, 16'd3, 1'b0), t3);
    wait_idle(40, ok);
    n_cmp++;
    if (alu_log[t1+1] !== {8'd10, 8'd20, 3'd0}) begin
      n_err++;
      $display("FAIL illegal_prev_slot got=%h required=%h", alu_log[t1+1], {8'd10, 8'd20, 3'd0});
    end
    n_cmp++;
    if (alu_log[t2+1] !== 19'd0) begin
      n_err++;
      $display("FAIL illegal_alu_zero got=%h required=0", alu_log[t2+1]);
    end
    n_cmp++;
    if (!ok || n_rsp - n0 != 3 || t3 - t1 != 2) begin
      n_err++;
      $display("FAIL illegal_count idle=%b responses=%0d spacing=%0d required 1 3 2", ok, n_rsp - n0, t3 - t1);
    end
  endtask

  task automatic test_random();
    int t, n0;
    bit ok;
    logic [7:0] a, b;
    logic [2:0] op;
    rand_rdy = 1'b1;
    n0 = n_rsp;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = 3'($urandom_range(0, 6));
      if (a == 8'd0 && b == 8'd0 && op == 3'd0) a = 8'd1;
      send(a, b, op, TAG_W'(i), mk(TAG_W'(i), op, alu_f(a, b, op), 1'b0), t);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 1'b0;
    rsp_ready_i = 1'b1;
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || n_rsp - n0 != 1000 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL random_count idle=%b responses=%0d pending=%0d required 1 1000 0", ok, n_rsp - n0, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, n0;
    bit acc = 1'b0, ok, stale = 1'b0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(8'(i + 1), 8'd1, 3'd0, TAG_W'(i), mk(TAG_W'(i), 3'd0, 16'(i + 2), 1'b0), t);
    for (int i = 0; i < 8; i++) tick();
    for (int i = 4; i < 8; i++)
      send(8'(i + 1), 8'd1, 3'd0, TAG_W'(i), mk(TAG_W'(i), 3'd0, 16'(i + 2), 1'b0), t);
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (!acc) offer(8'd50, 8'd50, 3'd0, 4'd8, mk(4'd8, 3'd0, 16'd100, 1'b0), acc);
      else tick();
    end
    rsp_ready_i = 1'b0;
    #2 reset_p_i = 1'b1;
    sb_q.delete();
    #1;
    n_cmp++;
    if ({req_ready_o, alu_a_o, alu_b_o, alu_inst_o} !== {1'b1, 19'd0}) begin
      n_err++;
      $display("FAIL midreset_req_alu got rdy=%b a=%h b=%h inst=%0d required 1 0 0 0",
               req_ready_o, alu_a_o, alu_b_o, alu_inst_o);
    end
    n_cmp++;
    if ({rsp_valid_o, rsp_data_o, rsp_inst_o, rsp_tag_o, rsp_err_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL midreset_rsp got valid=%b data=%h tag=%0d busy=%b required all 0",
               rsp_valid_o, rsp_data_o, rsp_tag_o, busy_o);
    end
    tick(); tick();
    reset_p_i = 1'b0;
    rsp_ready_i = 1'b1;
    n0 = n_rsp;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o) stale = 1'b1;
      tick();
    end
    n_cmp++;
    if (stale || n_rsp != n0) begin
      n_err++;
      $display("FAIL midreset_stale got valid_seen=%b responses=%0d required 0 0", stale, n_rsp - n0);
    end
    send(8'd33, 8'd44, 3'd4, 4'd5, mk(4'd5, 3'd4, 16'(8'd33 ^ 8'd44), 1'b0), t);
    check_latency("midreset", t);
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || n_rsp - n0 != 1 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_next idle=%b responses=%0d pending=%0d required 1 1 0", ok, n_rsp - n0, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d required=finish before timeout", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
